// File: rtl/sfpp_reconfig_pkg.sv
// Shared framing FSM encoding and drop counter constants for the reconfigurable
// packet-to-beat adapter.
package sfpp_reconfig_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_e;

  localparam int unsigned DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(255);

endpackage

// File: rtl/sfpp_reconfig_skid_buf.sv
// Two-entry skid buffer: output register plus one skid register.
// The upstream ready is registered and is high exactly when the skid entry is free.
module sfpp_reconfig_skid_buf #(
  parameter int unsigned W = 18
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  input  logic         m_ready
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         rdy_q, rdy_d;
  logic         drain_c;

  // s_valid is only raised while s_ready is high, so a push never meets a full skid entry.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    drain_c      = out_valid_q & m_ready;
    if (s_valid) begin
      if (!out_valid_q || drain_c) begin
        out_valid_d = 1'b1;
        out_data_d  = s_data;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = s_data;
      end
    end else if (drain_c) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    rdy_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      rdy_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      rdy_q        <= rdy_d;
    end
  end

  assign s_ready = rdy_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

endmodule

// File: rtl/sfpp_reconfig_p2b_adapter.sv
// Packet framing adapter: stamps a per-packet channel, drops beats outside packets,
// flags framing errors and feeds a two-entry skid buffer.
module sfpp_reconfig_p2b_adapter
  import sfpp_reconfig_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CHAN_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [CHAN_W-1:0] cfg_channel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_startofpacket,
  input  logic              in_endofpacket,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CHAN_W-1:0] out_channel,
  output logic              out_startofpacket,
  output logic              out_endofpacket,
  output logic              err_sticky,
  output logic [DROP_W-1:0] drop_count
);

  localparam int unsigned PAY_W = DATA_W + CHAN_W + 2;

  state_e            state_q, state_d;
  logic [CHAN_W-1:0] chan_q, chan_d;
  logic              err_q, err_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              accept_c;
  logic              push_c;
  logic [CHAN_W-1:0] push_chan_c;
  logic [PAY_W-1:0]  push_data_c;
  logic [PAY_W-1:0]  buf_data;

  // Framing decisions are taken only on accepted beats.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    err_d       = err_q;
    drop_d      = drop_q;
    push_c      = 1'b0;
    push_chan_c = chan_q;
    accept_c    = in_valid & in_ready;
    if (accept_c) begin
      if (in_startofpacket) begin
        if (state_q == ST_IN_PKT) err_d = 1'b1;
        chan_d      = cfg_channel;
        push_chan_c = cfg_channel;
        push_c      = 1'b1;
        state_d     = in_endofpacket ? ST_IDLE : ST_IN_PKT;
      end else if (state_q == ST_IDLE) begin
        err_d = 1'b1;
        if (drop_q != DROP_MAX) drop_d = drop_q + DROP_W'(1);
      end else begin
        push_c = 1'b1;
        if (in_endofpacket) state_d = ST_IDLE;
      end
    end
    push_data_c = {in_data, push_chan_c, in_startofpacket, in_endofpacket};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      err_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  sfpp_reconfig_skid_buf #(
    .W(PAY_W)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .s_valid (push_c),
    .s_data  (push_data_c),
    .s_ready (in_ready),
    .m_valid (out_valid),
    .m_data  (buf_data),
    .m_ready (out_ready)
  );

  assign {out_data, out_channel, out_startofpacket, out_endofpacket} = buf_data;
  assign err_sticky = err_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_sfpp_reconfig_p2b_adapter.sv
// Bench for the packet framing adapter: directed scenarios plus random traffic,
// checked against a queue-based packet model.
module tb_sfpp_reconfig_p2b_adapter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] cfg_channel = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       in_startofpacket = 1'b0;
  logic       in_endofpacket = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_channel;
  logic       out_startofpacket;
  logic       out_endofpacket;
  logic       err_sticky;
  logic [7:0] drop_count;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n0;

  // Model: beats in flight as {data, channel, sop, eop}, plus framing state.
  logic [17:0] expq[$];
  bit          in_pkt;
  logic [7:0]  pkt_chan;
  bit          m_err;
  int          m_drop;
  bit          acc_last;

  sfpp_reconfig_p2b_adapter #(.DATA_W(8), .CHAN_W(8)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .cfg_channel       (cfg_channel),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .err_sticky        (err_sticky),
    .drop_count        (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    in_pkt   = 0;
    pkt_chan = '0;
    m_err    = 0;
    m_drop   = 0;
  endtask

  task automatic model_accept();
    if (in_startofpacket) begin
      if (in_pkt) m_err = 1;
      pkt_chan = cfg_channel;
      expq.push_back({in_data, cfg_channel, 1'b1, in_endofpacket});
      in_pkt = !in_endofpacket;
    end else if (!in_pkt) begin
      m_err = 1;
      if (m_drop < 255) m_drop++;
    end else begin
      expq.push_back({in_data, pkt_chan, 1'b0, in_endofpacket});
      in_pkt = !in_endofpacket;
    end
  endtask

  // One clock: compare outputs at the falling edge, advance the model, return at posedge+1.
  task automatic cycle();
    bit acc, drn;
    @(negedge clk);
    chk("out_valid", out_valid, expq.size() != 0);
    if (expq.size() != 0)
      chk("out_beat", {out_data, out_channel, out_startofpacket, out_endofpacket}, expq[0]);
    chk("in_ready", in_ready, expq.size() < 2);
    chk("err_sticky", err_sticky, m_err);
    chk("drop_count", drop_count, m_drop);
    acc = in_valid && (expq.size() < 2);
    drn = (expq.size() != 0) && out_ready;
    if (drn) begin
      void'(expq.pop_front());
      n_out++;
    end
    if (acc) model_accept();
    acc_last = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop);
    in_valid = 1'b1;
    in_data = d;
    in_startofpacket = sop;
    in_endofpacket = eop;
    acc_last = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (acc_last) break;
    end
    chk("accept_timeout", acc_last, 1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_channel", out_channel, 0);
    chk("rst_out_sop", out_startofpacket, 0);
    chk("rst_out_eop", out_endofpacket, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_err_sticky", err_sticky, 0);
    chk("rst_drop_count", drop_count, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", in_ready, 1);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Four-beat packet, no backpressure, latency one.
    cfg_channel = 8'd3;
    out_ready = 1'b1;
    n0 = n_out;
    send_beat(8'h11, 1'b1, 1'b0);
    chk("lat1_valid", out_valid, 1);
    chk("lat1_data", out_data, 8'h11);
    chk("lat1_chan", out_channel, 3);
    send_beat(8'h12, 1'b0, 1'b0);
    send_beat(8'h13, 1'b0, 1'b0);
    send_beat(8'h14, 1'b0, 1'b1);
    chk("lat1_eop", out_endofpacket, 1);
    idle(4);
    chk("pkt4_count", n_out - n0, 4);

    // Backpressure mid-packet fills both entries.
    cfg_channel = 8'd4;
    send_beat(8'h21, 1'b1, 1'b0);
    out_ready = 1'b0;
    send_beat(8'h22, 1'b0, 1'b0);
    chk("stall_in_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data = 8'h23;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
    idle(3);
    chk("stall_hold_data", out_data, 8'h21);
    out_ready = 1'b1;
    send_beat(8'h23, 1'b0, 1'b0);
    send_beat(8'h24, 1'b0, 1'b1);
    idle(4);

    // Channel change mid-packet is ignored until the next SOP.
    cfg_channel = 8'd2;
    send_beat(8'h31, 1'b1, 1'b0);
    cfg_channel = 8'd9;
    send_beat(8'h32, 1'b0, 1'b0);
    chk("chan_hold", out_channel, 2);
    send_beat(8'h33, 1'b0, 1'b1);
    chk("chan_hold_eop", out_channel, 2);
    send_beat(8'h41, 1'b1, 1'b1);
    chk("chan_new", out_channel, 9);
    idle(3);

    // Single-beat packet leaves the FSM idle, so a following SOP=0 beat is dropped.
    chk("err_clear_before", err_sticky, 0);
    cfg_channel = 8'd7;
    send_beat(8'h5A, 1'b1, 1'b1);
    chk("single_data", out_data, 8'h5A);
    chk("single_chan", out_channel, 7);
    chk("single_sop", out_startofpacket, 1);
    chk("single_eop", out_endofpacket, 1);
    send_beat(8'hAA, 1'b0, 1'b0);
    idle(2);
    chk("drop_err", err_sticky, 1);
    chk("drop_one", drop_count, 1);
    for (int i = 0; i < 299; i++) send_beat(8'hAA, 1'b0, 1'b0);
    idle(2);
    chk("drop_sat", drop_count, 255);

    // Reset mid-packet with both entries occupied.
    cfg_channel = 8'd5;
    out_ready = 1'b0;
    send_beat(8'h51, 1'b1, 1'b0);
    send_beat(8'h52, 1'b0, 1'b0);
    chk("full_before_rst", in_ready, 0);
    do_reset();
    out_ready = 1'b1;
    send_beat(8'h61, 1'b0, 1'b0);
    idle(2);
    chk("post_rst_idle_drop", drop_count, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      in_startofpacket = ($urandom_range(0, 3) == 0);
      in_endofpacket = ($urandom_range(0, 3) == 0);
      cfg_channel = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sfpp_reconfig_p2b_adapter.md
SFPP_RECONFIG_P2B_ADAPTER -- requirements
Module: sfpp_reconfig_p2b_adapter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits.
REQ-002 SHALL have parameter CHAN_W, default 8, channel width in bits.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port cfg_channel, input, CHAN_W, channel stamped on packets; sampled only at accepted SOP.
REQ-006 SHALL have port in_valid, input, 1, sink beat valid.
REQ-007 SHALL have port in_ready, output, 1, sink may accept beat.
REQ-008 SHALL have port in_data, input, DATA_W, sink payload.
REQ-009 SHALL have ports in_startofpacket and in_endofpacket, input, 1 each, sink packet delimiters.
REQ-010 SHALL have port out_ready, input, 1, source backpressure.
REQ-011 SHALL have port out_valid, output, 1, source beat valid.
REQ-012 SHALL have port out_data, output, DATA_W, source payload.
REQ-013 SHALL have port out_channel, output, CHAN_W, channel of the current beat.
REQ-014 SHALL have ports out_startofpacket and out_endofpacket, output, 1 each, source delimiters.
REQ-015 SHALL have port err_sticky, output, 1, set on any framing error, cleared only by reset.
REQ-016 SHALL have port drop_count, output, 8, count of discarded beats, saturating at 255.

Function
REQ-017 SHALL accept a sink beat when in_valid and in_ready are both high in the same cycle.
REQ-018 SHALL implement a 2-entry skid buffer: the output register plus one skid register.
REQ-019 SHALL drive in_ready from a register: in_ready is high iff the skid register is empty.
REQ-020 SHALL present an accepted beat on the source at the earliest one cycle after acceptance (latency 1).
REQ-021 SHALL sustain one beat per cycle while out_ready is held high.
REQ-022 SHALL hold out_valid and all out_* payload stable while out_valid=1 and out_ready=0.
REQ-023 SHALL implement framing FSM states IDLE (between packets) and IN_PKT (inside a packet).
REQ-024 SHALL, in IDLE, on an accepted beat with SOP=1 and EOP=0: latch cfg_channel, forward the beat, and go to IN_PKT.
REQ-025 SHALL, in IDLE, on an accepted beat with SOP=1 and EOP=1: latch cfg_channel, forward the beat as a single-beat packet, and stay in IDLE.
REQ-026 SHALL, in IDLE, discard an accepted beat with SOP=0, set err_sticky, and increment drop_count.
REQ-027 SHALL, in IN_PKT, forward accepted beats with the latched channel, and go to IDLE on EOP=1.
REQ-028 SHALL, in IN_PKT, treat an accepted beat with SOP=1 as a new packet: set err_sticky, relatch cfg_channel, and forward the beat with SOP=1 (no beat is dropped).
REQ-029 SHALL give every beat of a packet the same out_channel, even if cfg_channel changes mid-packet.
REQ-030 SHALL update the FSM and counter only on accepted beats; discarded beats never occupy buffer entries.
REQ-031 SHALL, when an input beat is accepted and an output beat is drained in the same cycle, keep buffer occupancy unchanged and preserve beat order.

Reset
REQ-032 SHALL, while reset_n=0, asynchronously force: FSM=IDLE; both buffer entries empty; out_valid=0, out_data=0, out_channel=0, out_startofpacket=0, out_endofpacket=0; in_ready=0; err_sticky=0; drop_count=0.
REQ-033 SHALL set in_ready=1 on the first rising clk edge after reset_n deasserts.
REQ-034 SHALL discard buffered beats on a reset asserted mid-packet; the next accepted beat is judged in IDLE.

Structure
REQ-035 SHALL place the FSM state encoding and the drop_count saturation constant in a shared package, sfpp_reconfig_pkg.
REQ-036 SHALL implement the skid buffer as a sub-module, sfpp_reconfig_skid_buf, parameterised on total payload width (DATA_W+CHAN_W+2).

Verification
REQ-037 SHALL verify: cfg_channel=3, 4-beat packet 0x11..0x14, out_ready=1 -> 4 out beats, channel 3, SOP on 0x11, EOP on 0x14, 1-cycle latency.
REQ-038 SHALL verify: out_ready=0 for 3 cycles mid-packet -> in_ready low after 2 beats held, out beat stable, no loss or reorder after release.
REQ-039 SHALL verify: beat 0xAA with SOP=0 in IDLE -> no output, err_sticky=1, drop_count=1; 300 such beats -> drop_count=255.
REQ-040 SHALL verify: SOP+EOP single beat 0x5A, cfg_channel=7 -> one out beat, channel 7, both flags set, FSM stays IDLE.
REQ-041 SHALL verify: cfg_channel changes 2->9 mid-packet -> remaining beats keep channel 2; next packet uses 9.
REQ-042 SHALL verify: reset_n pulsed low mid-packet with buffer full -> all outputs zero immediately; in_ready=1 one edge after release; err_sticky=0.
